gf_mult_arbiter: RTL and testbench
==================================

GF_MULT_ARBITER -- requirements
Module: gf_mult_arbiter

Interface
REQ-001 Parameter m, default 16: field degree, operand and result width; field polynomial x^16+x^5+x^3+x^2+1 (0x1002D).
REQ-002 Parameter NREQ, default 4: number of requesters sharing one multiplier.
REQ-003 Parameter MUL_LAT, default 1: clock edges from mul_a/mul_b applied to mul_c valid.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  NREQ  bit i: requester i presents an operand pair.
REQ-007 req_a  in  NREQ*m  requester i operand A at bits [i*m +: m].
REQ-008 req_b  in  NREQ*m  requester i operand B at bits [i*m +: m].
REQ-009 req_ready  out  NREQ  one-hot-or-zero grant; combinational from req_valid and rr pointer.
REQ-010 mul_a  out  m  registered operand A to the shared GF multiplier.
REQ-011 mul_b  out  m  registered operand B to the shared GF multiplier.
REQ-012 mul_c  in  m  product returned by the multiplier.
REQ-013 rsp_valid  out  NREQ  one-hot-or-zero: rsp_data belongs to requester i this cycle.
REQ-014 rsp_data  out  m  product; equals mul_c.
REQ-015 busy  out  1  any req_valid high or any op in flight.
REQ-016 issue_cnt  out  16  count of accepted ops, wraps 0xFFFF->0x0000.

Function
REQ-017 Transfer occurs on requester i when req_valid[i] & req_ready[i] at a rising edge.
REQ-018 At most one req_ready bit high per cycle; req_ready[i] never high while req_valid[i] low.
REQ-019 Round-robin: search starts at index ptr+1 mod NREQ, first valid wins; ptr <= granted index on transfer only, unchanged otherwise.
REQ-020 On transfer, mul_a/mul_b <= granted slices at same edge; with no transfer, mul_a/mul_b <= 0.
REQ-021 Tag pipeline of depth 1+MUL_LAT carries {valid, index}; rsp_valid[idx] asserted exactly when the tag reaches the end.
REQ-022 Latency: transfer in cycle t -> rsp_valid in cycle t+1+MUL_LAT (t+2 at default); rsp_valid high exactly one cycle per op.
REQ-023 Throughput: one transfer per cycle sustained; responses emerge in issue order.
REQ-024 No response backpressure: requester samples rsp_data in the rsp_valid cycle.
REQ-025 Single continuous requester granted every cycle; requester dropping req_valid loses no fairness credit.
REQ-026 All NREQ valid continuously, ptr=0 -> grant order 1,2,3,0,1,...
REQ-027 issue_cnt increments by 1 per transfer, never more than 1 per cycle.

Reset
REQ-028 On rst high at an edge: ptr <= NREQ-1 (first grant searches from index 0), tag pipeline cleared, mul_a/mul_b <= 0, issue_cnt <= 0.
REQ-029 While rst high, req_ready = 0 and rsp_valid = 0.
REQ-030 Reset mid-operation: in-flight ops discarded, no rsp_valid for them after rst release.
REQ-031 busy = 0 after reset until a req_valid rises.

Verification
REQ-032 After reset, req_valid=0001, A=0x8421, B=0x0002 one cycle -> req_ready=0001 same cycle; rsp_valid=0001, rsp_data=0x086F two cycles later; issue_cnt=1.
REQ-033 req_valid=1111 held 8 cycles after reset, all A=0x1234 B=0x0002 -> grants 0,1,2,3,0,1,2,3; rsp_valid follows same order at +2, each rsp_data=0x2468.
REQ-034 Requester 2 alone, A=0xFFFF B=0x0001, 5 cycles back-to-back -> 5 consecutive rsp_valid=0100, rsp_data=0xFFFF.
REQ-035 Issue ops in consecutive cycles from req 1 and 3, assert rst for one cycle before responses -> no rsp_valid afterward, issue_cnt=0, mul_a=mul_b=0.
REQ-036 Force issue_cnt to 0xFFFF via 65535 transfers, one more transfer -> issue_cnt=0x0000.
REQ-037 Random valid patterns vs reference model: rsp order, tags and GF products match; no two req_ready bits ever high.

Source files
------------

// File: rtl/gf_mult_arbiter.sv
// Round-robin arbiter that time-shares one external GF(2^m) multiplier among NREQ requesters.
// Each accepted operand pair is tagged with its requester index so the product is routed back.
module gf_mult_arbiter #(
    parameter int m       = 16,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*m-1:0] req_a,
    input  logic [NREQ*m-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [m-1:0]      mul_a,
    output logic [m-1:0]      mul_b,
    input  logic [m-1:0]      mul_c,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [m-1:0]      rsp_data,
    output logic              busy,
    output logic [15:0]       issue_cnt
);

    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DEPTH = 1 + MUL_LAT;

    logic [IW-1:0]   r_ptr;
    logic [m-1:0]    r_mul_a;
    logic [m-1:0]    r_mul_b;
    logic [15:0]     r_issue_cnt;
    logic [DEPTH-1:0] r_tag_vld;
    logic [IW-1:0]   r_tag_idx [DEPTH];

    logic            w_grant_vld;
    logic [IW-1:0]   w_grant_idx;
    logic [IW-1:0]   w_cand;
    logic            w_xfer;
    logic [m-1:0]    w_a_slice [NREQ];
    logic [m-1:0]    w_b_slice [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_a_slice[gi] = req_a[gi*m +: m];
            assign w_b_slice[gi] = req_b[gi*m +: m];
        end
    endgenerate

    // Search begins one past the last winner, so a requester that drops out keeps its turn.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_grant_vld && req_valid[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_xfer = w_grant_vld & ~rst;

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= IW'(NREQ - 1);
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_issue_cnt <= '0;
        end else if (w_xfer) begin
            r_ptr       <= w_grant_idx;
            r_mul_a     <= w_a_slice[w_grant_idx];
            r_mul_b     <= w_b_slice[w_grant_idx];
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end else begin
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end
    end

    // Tag shift register is aligned so its last stage coincides with mul_c for that op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag_idx[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
            r_tag_vld[0] <= w_xfer;
            r_tag_idx[0] <= w_grant_idx;
        end
    end

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = ~rst & r_tag_vld[DEPTH-1] & (r_tag_idx[DEPTH-1] == IW'(gi));
        end
    endgenerate

    assign rsp_data  = mul_c;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign issue_cnt = r_issue_cnt;
    assign busy      = (|req_valid) | (|r_tag_vld);

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// Directed and random checks of gf_mult_arbiter with a one-cycle GF(2^16) multiplier model.
module tb_gf_mult_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_c;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic [15:0] issue_cnt;

    gf_mult_arbiter #(.m(16), .NREQ(4), .MUL_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .issue_cnt(issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        logic [15:0] x;
        p = 16'h0;
        x = a;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) p = p ^ x;
            x = x[15] ? ((x << 1) ^ 16'h002D) : (x << 1);
        end
        return p;
    endfunction

    // Multiplier with one cycle of latency.
    always @(posedge clk) mul_c <= gf_mul(mul_a, mul_b);

    typedef struct {
        logic        do_rst;
        logic [3:0]  v;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  er;
    } vec_t;

    vec_t tbl[$];

    int          n_vec;
    int          n_err;
    logic [3:0]  e1_v, e2_v;
    logic [15:0] e1_d, e2_d;
    logic [15:0] cnt_m;
    int          m_ptr;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [63:0] a,
                                input logic [63:0] b, input logic [3:0] er);
        vec_t t;
        t.do_rst = r; t.v = v; t.a = a; t.b = b; t.er = er;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        e1_v = '0; e2_v = '0; e1_d = '0; e2_d = '0;
        cnt_m = '0; m_ptr = 3;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 4'h0;
        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_issue_cnt", 64'(issue_cnt), 64'h0);
        chk("rst_mul_a", 64'(mul_a), 64'h0);
        chk("rst_mul_b", 64'(mul_b), 64'h0);
        clear_model();
    endtask

    task automatic step(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] er, input string nm);
        logic [15:0] ga, gb;
        logic        exp_busy;
        req_valid = v; req_a = a; req_b = b;
        #1;
        chk({nm, " ready"}, 64'(req_ready), 64'(er));
        chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(e2_v));
        if (e2_v != 4'h0) chk({nm, " rsp_data"}, 64'(rsp_data), 64'(e2_d));
        exp_busy = (v != 4'h0) || (e1_v != 4'h0) || (e2_v != 4'h0);
        chk({nm, " busy"}, 64'(busy), 64'(exp_busy));
        ga = '0; gb = '0;
        for (int i = 0; i < 4; i++) begin
            if (er[i]) begin
                ga = a[i*16 +: 16];
                gb = b[i*16 +: 16];
                m_ptr = i;
            end
        end
        e2_v = e1_v; e2_d = e1_d;
        e1_v = er;   e1_d = (er != 4'h0) ? gf_mul(ga, gb) : 16'h0;
        if (er != 4'h0) cnt_m = cnt_m + 16'd1;
        $display("vec %s: valid=%b ready=%b rsp_valid=%b rsp_data=%h", nm, v, req_ready, rsp_valid, rsp_data);
        @(posedge clk); #1;
        chk({nm, " mul_a"}, 64'(mul_a), 64'(ga));
        chk({nm, " mul_b"}, 64'(mul_b), 64'(gb));
        chk({nm, " issue_cnt"}, 64'(issue_cnt), 64'(cnt_m));
    endtask

    function automatic logic [3:0] rr_model(input logic [3:0] v, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (v[(ptr + k) % 4]) return 4'(1 << ((ptr + k) % 4));
        end
        return 4'h0;
    endfunction

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        clear_model();

        // Single op from requester 0
        tbl.push_back(mk(1, 4'h0, 64'h0, 64'h0, 4'h0));
        tbl.push_back(mk(0, 4'b0001, 64'h0000_0000_0000_8421, 64'h0000_0000_0000_0002, 4'b0001));
        tbl.push_back(mk(0, 4'h0, 64'h0, 64'h0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 64'h0, 64'h0, 4'h0));
        // All requesters continuously after reset: grants 0,1,2,3,0,1,2,3
        tbl.push_back(mk(1, 4'h0, 64'h0, 64'h0, 4'h0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 4'hF, {4{16'h1234}}, {4{16'h0002}}, 4'(1 << (i % 4))));
        tbl.push_back(mk(0, 4'h0, 64'h0, 64'h0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 64'h0, 64'h0, 4'h0));
        // Requester 2 alone, back-to-back
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b0100, 64'h0000_FFFF_0000_0000, 64'h0000_0001_0000_0000, 4'b0100));
        tbl.push_back(mk(0, 4'h0, 64'h0, 64'h0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 64'h0, 64'h0, 4'h0));
        // Mixed patterns with ptr=2, distinct operands per requester
        tbl.push_back(mk(0, 4'b1010, 64'hA5A5_0003_5A5A_0001, 64'h8001_0007_F00F_0002, 4'b1000));
        tbl.push_back(mk(0, 4'b1010, 64'hA5A5_0003_5A5A_0001, 64'h8001_0007_F00F_0002, 4'b0010));
        tbl.push_back(mk(0, 4'b0011, 64'hA5A5_0003_5A5A_C001, 64'h8001_0007_F00F_8000, 4'b0001));
        tbl.push_back(mk(0, 4'b0110, 64'h1111_FEDC_ABCD_C001, 64'h2222_8000_1357_8000, 4'b0010));
        tbl.push_back(mk(0, 4'b0110, 64'h1111_FEDC_ABCD_C001, 64'h2222_8000_1357_8000, 4'b0100));
        tbl.push_back(mk(0, 4'b1001, 64'h8000_FEDC_ABCD_7FFF, 64'h8000_8000_1357_FFFF, 4'b1000));
        tbl.push_back(mk(0, 4'b1001, 64'h8000_FEDC_ABCD_7FFF, 64'h8000_8000_1357_FFFF, 4'b0001));
        tbl.push_back(mk(0, 4'h0, 64'h0, 64'h0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 64'h0, 64'h0, 4'h0));

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            else step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].er, $sformatf("tbl%0d", i));
        end

        // Reset while two ops are in flight: neither may respond
        do_reset();
        step(4'b0010, 64'h0000_0000_1234_0000, 64'h0000_0000_0003_0000, 4'b0010, "rstmid0");
        step(4'b1000, 64'h4321_0000_0000_0000, 64'h0005_0000_0000_0000, 4'b1000, "rstmid1");
        rst = 1'b1; req_valid = 4'h0;
        #1;
        chk("rstmid rsp_valid during rst", 64'(rsp_valid), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstmid issue_cnt", 64'(issue_cnt), 64'h0);
        chk("rstmid mul_a", 64'(mul_a), 64'h0);
        chk("rstmid mul_b", 64'(mul_b), 64'h0);
        clear_model();
        for (int i = 0; i < 3; i++) step(4'h0, 64'h0, 64'h0, 4'h0, $sformatf("rstmid_idle%0d", i));

        // issue_cnt wrap
        do_reset();
        req_valid = 4'b0001;
        repeat (65535) @(posedge clk);
        #1;
        req_valid = 4'h0;
        chk("wrap cnt_ffff", 64'(issue_cnt), 64'hFFFF);
        $display("vec wrap: issue_cnt=%h", issue_cnt);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = 4'h0;
        chk("wrap cnt_0000", 64'(issue_cnt), 64'h0);
        $display("vec wrap: issue_cnt=%h", issue_cnt);

        // Random traffic against the round-robin model
        do_reset();
        for (int i = 0; i < 200; i++) begin
            logic [3:0]  rv;
            logic [63:0] ra, rb;
            rv = 4'($urandom_range(0, 15));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            step(rv, ra, rb, rr_model(rv, m_ptr), $sformatf("rnd%0d", i));
        end
        step(4'h0, 64'h0, 64'h0, 4'h0, "rnd_flush0");
        step(4'h0, 64'h0, 64'h0, 4'h0, "rnd_flush1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
